// File: rtl/qspi_flash_reader.sv
// qspi_flash_reader: single-lane SPI (mode 0) reader issuing READ (0x03)
// with a 24-bit address and returning DATA_BYTES bytes little-endian.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   req_valid/req_ready  request handshake, req_addr captured on accept
//   resp_valid           one-cycle pulse, resp_data held until next pulse
//   cs, sclk, si, so     flash pins (cs active low, sclk idle low)
//   wp, hold             flash control pins, tied inactive (high)

`ifndef XLEN
`define XLEN 64
`endif

module qspi_flash_reader #(
    parameter int DATA_BYTES = `XLEN / 8,
    parameter int CS_GAP     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [23:0]             req_addr,
    output logic                    resp_valid,
    output logic [8*DATA_BYTES-1:0] resp_data,
    output logic                    cs,
    output logic                    sclk,
    output logic                    si,
    input  logic                    so,
    output logic                    wp,
    output logic                    hold
);

    localparam int DW    = 8 * DATA_BYTES;
    localparam int NBITS = 32 + DW;
    localparam int CW    = $clog2(NBITS + 1);
    localparam int GMAX  = (CS_GAP < 1) ? 1 : CS_GAP;
    localparam int GW    = $clog2(GMAX + 2);

    localparam logic [CW-1:0] LAST_BIT = CW'(NBITS - 1);
    localparam logic [CW-1:0] HDR_BITS = CW'(32);
    localparam logic [GW-1:0] GAP_LAST = GW'(GMAX);
    localparam logic [7:0]    CMD_READ = 8'h03;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    state_t          state;
    logic [CW-1:0]   bit_idx;
    logic            phase_h;
    logic [31:0]     tx_sr;
    logic [DW-2:0]   rx_sr;
    logic [DW-1:0]   rx_next;
    logic [DW-1:0]   rx_swap;
    logic [GW-1:0]   gap_cnt;

    assign wp   = 1'b1;
    assign hold = 1'b1;

    // Receive register fills MSB-first across the whole read; the first
    // byte received ends up in the top byte of rx_next.
    assign rx_next = {rx_sr, so};

    // Reorder so the first received byte lands in resp_data[7:0].
    always_comb begin
        rx_swap = '0;
        for (int k = 0; k < DATA_BYTES; k++) begin
            rx_swap[8*k +: 8] = rx_next[DW-8-8*k +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            cs         <= 1'b1;
            sclk       <= 1'b0;
            si         <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            bit_idx    <= '0;
            phase_h    <= 1'b0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            gap_cnt    <= '0;
        end else begin
            resp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        state     <= SHIFT;
                        req_ready <= 1'b0;
                        cs        <= 1'b0;
                        sclk      <= 1'b0;
                        si        <= CMD_READ[7];
                        // Remaining header bits; zeros shift in behind
                        // them so si is 0 during the data phase.
                        tx_sr     <= {CMD_READ[6:0], req_addr, 1'b0};
                        bit_idx   <= '0;
                        phase_h   <= 1'b0;
                        rx_sr     <= '0;
                    end
                end
                SHIFT: begin
                    if (!phase_h) begin
                        sclk    <= 1'b1;
                        phase_h <= 1'b1;
                    end else begin
                        // End of H phase: sample so, drop sclk, move si.
                        sclk    <= 1'b0;
                        phase_h <= 1'b0;
                        if (bit_idx >= HDR_BITS) begin
                            rx_sr <= rx_next[DW-2:0];
                        end
                        if (bit_idx == LAST_BIT) begin
                            state      <= GAP;
                            cs         <= 1'b1;
                            si         <= 1'b0;
                            resp_valid <= 1'b1;
                            resp_data  <= rx_swap;
                            gap_cnt    <= GW'(1);
                        end else begin
                            bit_idx <= bit_idx + CW'(1);
                            si      <= tx_sr[31];
                            tx_sr   <= {tx_sr[30:0], 1'b0};
                        end
                    end
                end
                GAP: begin
                    // The resp_valid cycle is the first gap cycle.
                    if (gap_cnt >= GAP_LAST) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    cs        <= 1'b1;
                    sclk      <= 1'b0;
                    si        <= 1'b0;
                end
            endcase
        end
    end

endmodule
